dbg_imem_target: RTL

- Target (receiving) end of the debug instruction-load interface (dbg_wr_en / dbg_addr / dbg_instr).
- Instruction memory that accepts debug loads while the core is halted, and serves core fetches once the core runs.
- After reset it sweeps the whole array to NOP, then accepts one write per rising edge of dbg_wr_en.
- Provides a registered fetch read port to the IF stage.

---
 rtl/dbg_imem_target.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dbg_imem_target.sv
// dbg_imem_target: instruction memory on the receiving end of the debug
// instruction-load interface. After reset the whole array is swept to NOP.
// After that it commits one debug write per rising edge of dbg_wr_en while
// the core is halted, and serves registered fetches once the core runs.
// Optional build macro: DBG_IMEM_READBACK_EN adds the dbg_rdata readback port.
module dbg_imem_target #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned INSTRUCTION_LENGTH = XLEN / 2,
    parameter int unsigned DEPTH              = 256,
    parameter logic [INSTRUCTION_LENGTH-1:0] NOP_WORD = INSTRUCTION_LENGTH'(32'h00000013)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dbg_wr_en,
    input  logic [XLEN-1:0]                 dbg_addr,
    input  logic [INSTRUCTION_LENGTH-1:0]   dbg_instr,
    input  logic                            fetch_en,
    input  logic [XLEN-1:0]                 fetch_addr,
    output logic [INSTRUCTION_LENGTH-1:0]   fetch_instr,
    output logic                            fetch_valid,
    output logic                            busy,
    output logic                            dbg_ack,
    output logic                            dbg_err,
    output logic [$clog2(DEPTH+1)-1:0]      load_count
`ifdef DBG_IMEM_READBACK_EN
    ,
    output logic [INSTRUCTION_LENGTH-1:0]   dbg_rdata
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = INSTRUCTION_LENGTH;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    logic [IW-1:0]   mem [DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            wr_prev_q;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic [IW-1:0]   pend_data_q, pend_data_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q;
    logic [IW-1:0]   fetch_instr_q, fetch_instr_d;
    logic            fetch_valid_q, fetch_valid_d;

    logic            edge_c;
    logic            req_valid_c;
    logic [XLEN-1:0] req_addr_c;
    logic [IW-1:0]   req_data_c;
    logic            req_in_range_c;
    logic            mem_we_c;
    logic [AW-1:0]   mem_waddr_c;
    logic [IW-1:0]   mem_wdata_c;
    logic [AW-1:0]   fetch_idx_c;
    logic            fetch_hit_c;

    assign edge_c      = dbg_wr_en & ~wr_prev_q;
    assign fetch_idx_c = fetch_addr[AW+1:2];
    assign fetch_hit_c = (fetch_addr[XLEN-1:AW+2] == '0) && (fetch_addr[1:0] == 2'b00);

    // Next-state, write-request arbitration and memory write port selection
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        pend_d         = pend_q;
        pend_addr_d    = pend_addr_q;
        pend_data_d    = pend_data_q;
        ack_d          = 1'b0;
        err_d          = 1'b0;
        cnt_d          = cnt_q;
        mem_we_c       = 1'b0;
        mem_waddr_c    = '0;
        mem_wdata_c    = NOP_WORD;
        req_valid_c    = 1'b0;
        req_addr_c     = dbg_addr;
        req_data_c     = dbg_instr;
        req_in_range_c = 1'b0;

        case (state_q)
            S_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = ptr_q;
                mem_wdata_c = NOP_WORD;
                ptr_d       = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
                // Only the most recent edge seen during the sweep survives
                if (edge_c) begin
                    pend_d      = 1'b1;
                    pend_addr_d = dbg_addr;
                    pend_data_d = dbg_instr;
                end
            end

            S_IDLE: begin
                // A fresh edge wins over a stale pending request
                if (edge_c) begin
                    req_valid_c = 1'b1;
                end else if (pend_q) begin
                    req_valid_c = 1'b1;
                    req_addr_c  = pend_addr_q;
                    req_data_c  = pend_data_q;
                end
                pend_d         = 1'b0;
                req_in_range_c = (req_addr_c[XLEN-1:AW] == '0);
                if (req_valid_c) begin
                    if (!fetch_en && req_in_range_c) begin
                        mem_we_c    = 1'b1;
                        mem_waddr_c = req_addr_c[AW-1:0];
                        mem_wdata_c = req_data_c;
                        state_d     = S_ACK;
                        ack_d       = 1'b1;
                        if (cnt_q != CW'(DEPTH)) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_ACK: begin
                state_d = S_IDLE;
                if (edge_c) begin
                    pend_d      = 1'b1;
                    pend_addr_d = dbg_addr;
                    pend_data_d = dbg_instr;
                end
            end

            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Fetch read port: one-cycle latency, holds data when idle or sweeping
    always_comb begin
        fetch_instr_d = fetch_instr_q;
        fetch_valid_d = 1'b0;
        if (fetch_en && (state_q != S_CLEAR)) begin
            fetch_valid_d = 1'b1;
            fetch_instr_d = fetch_hit_c ? mem[fetch_idx_c] : NOP_WORD;
        end
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_CLEAR;
            ptr_q         <= '0;
            wr_prev_q     <= 1'b0;
            pend_q        <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            fetch_instr_q <= NOP_WORD;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wr_prev_q     <= dbg_wr_en;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            busy_q        <= (state_d == S_CLEAR);
            fetch_instr_q <= fetch_instr_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    // Instruction array; contents only change through the sweep or debug writes
    always_ff @(posedge clk) begin
        if (rst && mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

`ifdef DBG_IMEM_READBACK_EN
    logic [IW-1:0] rdata_q, rdata_d;
    logic          rb_hit_c;

    assign rb_hit_c = (dbg_addr[XLEN-1:AW] == '0);

    // Loader readback: sample the addressed word while halted and quiet
    always_comb begin
        rdata_d = rdata_q;
        if (!dbg_wr_en && !fetch_en && (state_q == S_IDLE)) begin
            rdata_d = rb_hit_c ? mem[dbg_addr[AW-1:0]] : NOP_WORD;
        end
    end

    // Readback register
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign dbg_rdata = rdata_q;
`endif

    assign fetch_instr = fetch_instr_q;
    assign fetch_valid = fetch_valid_q;
    assign busy        = busy_q;
    assign dbg_ack     = ack_q;
    assign dbg_err     = err_q;
    assign load_count  = cnt_q;

endmodule
